// File: rtl/seq_gen_tx.sv
// Purpose : serial bit-stream transmitter; sends a WIDTH-bit word MSB-first, one bit per clk.
// Latency : first bit on out the cycle after the handshake; done WIDTH(+stuffed bits)+1 cycles after it.
// Backpr. : load_ready is high only in IDLE; load_valid outside IDLE is ignored (no capture, no queue).
//
// Ports: clk, reset (async, active-high); load_valid/load_ready/data load handshake;
//        out (registered serial bit), busy (registered, SHIFT/STUFF/DONE), done (1-cycle pulse),
//        state (debug: IDLE=0 SHIFT=1 STUFF=2 DONE=3).
// Build option: define SEQ_GEN_STUFF_EN to insert a 0 after every RUN_MAX consecutive payload 1s.
module seq_gen_tx #(
    parameter int WIDTH   = 8,
    parameter int RUN_MAX = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data,
    output logic             out,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int RW = $clog2(RUN_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        STUFF = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;   // remaining payload, next bit at MSB
    logic [CW-1:0]    bits_q, bits_d;   // payload bits still to be presented
    logic [RW-1:0]    run_q, run_d;     // consecutive 1s currently on out
    logic             out_d, busy_d, done_d;
    logic             xfer;
    logic             last_bit;
    logic             stuff_now;

    assign load_ready = (state_q == IDLE);
    assign xfer       = load_valid && load_ready;
    assign last_bit   = (bits_q == '0);
    assign state      = state_q;

`ifdef SEQ_GEN_STUFF_EN
    // Stuff only while payload remains; after the final bit the idle 0 breaks the run.
    assign stuff_now = (run_q == RW'(RUN_MAX)) && !last_bit;
`else
    assign stuff_now = 1'b0;
`endif

    // Run length after emitting bit b; saturates so it never wraps in raw mode.
    function automatic logic [RW-1:0] run_next(input logic [RW-1:0] run, input logic b);
        if (!b)
            return '0;
        else if (run == RW'(RUN_MAX))
            return run;
        else
            return run + RW'(1);
    endfunction

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (xfer) state_d = SHIFT;
            SHIFT: begin
                if (last_bit)
                    state_d = DONE;
                else if (stuff_now)
                    state_d = STUFF;
            end
            STUFF:   state_d = SHIFT;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        sreg_d = sreg_q;
        bits_d = bits_q;
        run_d  = run_q;
        out_d  = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_q)
            IDLE: begin
                run_d = '0;
                if (xfer) begin
                    sreg_d = data << 1;
                    out_d  = data[WIDTH-1];
                    run_d  = data[WIDTH-1] ? RW'(1) : '0;
                    bits_d = CW'(WIDTH - 1);
                    busy_d = 1'b1;
                end
            end
            SHIFT: begin
                busy_d = 1'b1;
                if (last_bit) begin
                    done_d = 1'b1;
                    run_d  = '0;
                end else if (stuff_now) begin
                    run_d  = '0;
                end else begin
                    out_d  = sreg_q[WIDTH-1];
                    sreg_d = sreg_q << 1;
                    bits_d = bits_q - CW'(1);
                    run_d  = run_next(run_q, sreg_q[WIDTH-1]);
                end
            end
            STUFF: begin
                busy_d = 1'b1;
                out_d  = sreg_q[WIDTH-1];
                sreg_d = sreg_q << 1;
                bits_d = bits_q - CW'(1);
                run_d  = run_next('0, sreg_q[WIDTH-1]);
            end
            DONE: begin
                run_d = '0;
            end
            default: begin
                run_d = '0;
            end
        endcase
    end

    // Registered outputs and datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg_q <= '0;
            bits_q <= '0;
            run_q  <= '0;
            out    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            sreg_q <= sreg_d;
            bits_q <= bits_d;
            run_q  <= run_d;
            out    <= out_d;
            busy   <= busy_d;
            done   <= done_d;
        end
    end

endmodule
